// File: rtl/riscv_vec_alu_seq.sv
// riscv_vec_alu_seq: splits a vector ALU instruction into LANES-wide beats,
// drives a one-cycle-later regfile writeback and returns a completion response.
module riscv_vec_alu_seq #(
    parameter int NELEM = 8,
    parameter int LANES = 2,
    parameter int BEATW = 3
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             req_val_i,
    output logic             req_rdy_o,
    input  logic [3:0]       req_fn_i,
    input  logic [3:0]       req_vl_i,
    input  logic [NELEM-1:0] req_vm_i,
    input  logic [2:0]       req_vs1_i,
    input  logic [2:0]       req_vs2_i,
    input  logic [2:0]       req_vd_i,
    input  logic             stall_i,
    output logic             alu_val_o,
    output logic [3:0]       alu_fn_o,
    output logic [2:0]       alu_vs1_o,
    output logic [2:0]       alu_vs2_o,
    output logic [BEATW-1:0] alu_beat_o,
    output logic [LANES-1:0] alu_elem_en_o,
    output logic             wb_val_o,
    output logic [2:0]       wb_addr_o,
    output logic [BEATW-1:0] wb_beat_o,
    output logic [LANES-1:0] wb_elem_en_o,
    output logic             resp_val_o,
    input  logic             resp_rdy_i,
    output logic             resp_err_o,
    output logic             busy_o
);
    typedef enum logic [1:0] {IDLE, EXEC, DRAIN, RESP} state_t;
    state_t           state_q;
    logic [BEATW-1:0] beat_q;
    logic [3:0]       fn_q;
    logic [3:0]       vl_q;
    logic [NELEM-1:0] vm_q;
    logic [2:0]       vs1_q;
    logic [2:0]       vs2_q;
    logic [2:0]       vd_q;
    logic             err_q;
    logic             wb_val_q;
    logic [BEATW-1:0] wb_beat_q;
    logic [LANES-1:0] wb_en_q;
    logic [3:0]       vl_eff;
    logic [LANES-1:0] vm_sh;
    logic             last_beat;
    assign vl_eff     = (int'(req_vl_i) > NELEM) ? 4'(NELEM) : req_vl_i;
    assign vm_sh      = LANES'(vm_q >> (int'(beat_q) * LANES));
    assign last_beat  = (int'(beat_q) + 1) * LANES >= int'(vl_q);
    assign req_rdy_o  = reset_i && state_q == IDLE;
    assign alu_val_o  = reset_i && state_q == EXEC && !stall_i;
    assign resp_val_o = reset_i && state_q == RESP;
    assign busy_o     = reset_i && state_q != IDLE;
    assign alu_fn_o   = fn_q;
    assign alu_vs1_o  = vs1_q;
    assign alu_vs2_o  = vs2_q;
    assign alu_beat_o = beat_q;
    assign wb_val_o     = wb_val_q;
    assign wb_addr_o    = vd_q;
    assign wb_beat_o    = wb_beat_q;
    assign wb_elem_en_o = wb_en_q;
    assign resp_err_o   = err_q;
    for (genvar i = 0; i < LANES; i++) begin : g_en
        assign alu_elem_en_o[i] = vm_sh[i] && (int'(beat_q) * LANES + i < int'(vl_q));
    end
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            fn_q      <= '0;
            vl_q      <= '0;
            vm_q      <= '0;
            vs1_q     <= '0;
            vs2_q     <= '0;
            vd_q      <= '0;
            err_q     <= 1'b0;
            wb_val_q  <= 1'b0;
            wb_beat_q <= '0;
            wb_en_q   <= '0;
        end else begin
            wb_val_q  <= alu_val_o;
            wb_beat_q <= beat_q;
            wb_en_q   <= alu_elem_en_o;
            case (state_q)
                IDLE: if (req_val_i) begin
                    fn_q    <= req_fn_i;
                    vl_q    <= vl_eff;
                    vm_q    <= req_vm_i;
                    vs1_q   <= req_vs1_i;
                    vs2_q   <= req_vs2_i;
                    vd_q    <= req_vd_i;
                    err_q   <= req_fn_i > 4'd9;
                    beat_q  <= '0;
                    state_q <= (req_fn_i > 4'd9 || vl_eff == 4'd0) ? RESP : EXEC;
                end
                EXEC: if (!stall_i) begin
                    beat_q  <= beat_q + BEATW'(1);
                    state_q <= last_beat ? DRAIN : EXEC;
                end
                DRAIN: state_q <= RESP;
                RESP: state_q <= resp_rdy_i ? IDLE : RESP;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_riscv_vec_alu_seq.sv
// tb_riscv_vec_alu_seq: scoreboard bench; expected beats and responses come from an element-level model.
module tb_riscv_vec_alu_seq;
    localparam int NELEM = 8;
    localparam int LANES = 2;
    localparam int BEATW = 3;
    logic             clk = 0, reset = 0, req_val = 0, stall = 0, resp_rdy = 1;
    logic [3:0]       req_fn = '0, req_vl = '0;
    logic [NELEM-1:0] req_vm = '0;
    logic [2:0]       req_vs1 = '0, req_vs2 = '0, req_vd = '0;
    logic             req_rdy, alu_val, wb_val, resp_val, resp_err, busy;
    logic [3:0]       alu_fn;
    logic [2:0]       alu_vs1, alu_vs2, wb_addr;
    logic [BEATW-1:0] alu_beat, wb_beat;
    logic [LANES-1:0] alu_elem_en, wb_elem_en;
    typedef struct {int beat; int en; int fn; int vs1; int vs2; int vd;} beat_t;
    typedef struct {int err; int exp_cyc;} resp_t;
    beat_t alu_q[$], wb_q[$];
    resp_t resp_q[$];
    int vectors = 0, miscompares = 0, cyc = 0;
    int stall_lo = -10, stall_hi = -10, rdy_lo = -10, rdy_hi = -10, hs_cyc = -1, resp_start = 0;
    bit rand_mode = 0, prev_alu = 0, resp_prev = 0;
    riscv_vec_alu_seq #(.NELEM(NELEM), .LANES(LANES), .BEATW(BEATW)) dut (
        .clk_i(clk), .reset_i(reset), .req_val_i(req_val), .req_rdy_o(req_rdy),
        .req_fn_i(req_fn), .req_vl_i(req_vl), .req_vm_i(req_vm), .req_vs1_i(req_vs1),
        .req_vs2_i(req_vs2), .req_vd_i(req_vd), .stall_i(stall), .alu_val_o(alu_val),
        .alu_fn_o(alu_fn), .alu_vs1_o(alu_vs1), .alu_vs2_o(alu_vs2), .alu_beat_o(alu_beat),
        .alu_elem_en_o(alu_elem_en), .wb_val_o(wb_val), .wb_addr_o(wb_addr), .wb_beat_o(wb_beat),
        .wb_elem_en_o(wb_elem_en), .resp_val_o(resp_val), .resp_rdy_i(resp_rdy),
        .resp_err_o(resp_err), .busy_o(busy)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    // Datapath-side inputs: directed windows or random backpressure.
    initial forever begin
        @(posedge clk);
        #1;
        stall    = (cyc >= stall_lo && cyc <= stall_hi) || (rand_mode && $urandom_range(0, 3) == 0);
        resp_rdy = !(cyc >= rdy_lo && cyc <= rdy_hi) && !(rand_mode && $urandom_range(0, 2) == 0);
    end
    always @(negedge clk) begin
        beat_t e;
        resp_t r;
        if (alu_val) begin
            if (alu_q.size() == 0) check("alu_unexpected", 1, 0);
            else begin
                e = alu_q.pop_front();
                check("alu_beat", int'(alu_beat), e.beat);
                check("alu_en", int'(alu_elem_en), e.en);
                check("alu_fn", int'(alu_fn), e.fn);
                check("alu_vs1", int'(alu_vs1), e.vs1);
                check("alu_vs2", int'(alu_vs2), e.vs2);
            end
        end
        if (stall) check("alu_while_stall", int'(alu_val), 0);
        if (wb_val || prev_alu) check("wb_latency", int'(wb_val), int'(prev_alu));
        if (wb_val) begin
            if (wb_q.size() == 0) check("wb_unexpected", 1, 0);
            else begin
                e = wb_q.pop_front();
                check("wb_beat", int'(wb_beat), e.beat);
                check("wb_en", int'(wb_elem_en), e.en);
                check("wb_addr", int'(wb_addr), e.vd);
            end
        end
        if (reset && (alu_val || resp_val)) check("busy", int'(busy), 1);
        if (resp_val) check("req_rdy_in_resp", int'(req_rdy), 0);
        if (resp_val && !resp_prev) resp_start = cyc;
        if (resp_val && resp_rdy) begin
            if (resp_q.size() == 0) check("resp_unexpected", 1, 0);
            else begin
                r = resp_q.pop_front();
                check("resp_err", int'(resp_err), r.err);
                if (r.exp_cyc >= 0) check("resp_cycle", resp_start, r.exp_cyc);
            end
            hs_cyc = cyc;
        end
        prev_alu  = alu_val;
        resp_prev = resp_val;
    end
    task automatic issue(input int fn, input int vl, input int vm, input int vd,
                         input bit timed, input int stall_off, output int t);
        int v1, v2, vle, nb, en;
        beat_t e;
        resp_t r;
        v1 = $urandom_range(0, 7);
        v2 = $urandom_range(0, 7);
        @(posedge clk);
        #1;
        req_fn = 4'(fn); req_vl = 4'(vl); req_vm = NELEM'(vm);
        req_vs1 = 3'(v1); req_vs2 = 3'(v2); req_vd = 3'(vd); req_val = 1;
        t = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (req_rdy) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) begin
            check("accept_timeout", 0, 1);
            req_val = 0;
            return;
        end
        if (stall_off > 0) begin
            stall_lo = t + stall_off;
            stall_hi = t + stall_off + 1;
        end
        vle = vl > NELEM ? NELEM : vl;
        nb  = (fn > 9 || vle == 0) ? 0 : (vle + LANES - 1) / LANES;
        for (int b = 0; b < nb; b++) begin
            en = 0;
            for (int j = 0; j < LANES; j++)
                if (b * LANES + j < vle && ((vm >> (b * LANES + j)) & 1) != 0) en |= 1 << j;
            e.beat = b; e.en = en; e.fn = fn; e.vs1 = v1; e.vs2 = v2; e.vd = vd;
            alu_q.push_back(e);
            wb_q.push_back(e);
        end
        r.err = fn > 9 ? 1 : 0;
        r.exp_cyc = !timed ? -1 : (nb == 0 ? t + 1 : t + nb + 2 + (stall_off > 0 ? 2 : 0));
        resp_q.push_back(r);
        @(posedge clk);
        #1 req_val = 0;
    endtask
    task automatic wait_done();
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (alu_q.size() == 0 && wb_q.size() == 0 && resp_q.size() == 0 && !busy) return;
        end
        check("drain_timeout", 0, 1);
    endtask
    initial begin
        int t, ta, tb;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_rdy", int'(req_rdy), 0);
        check("rst_alu_val", int'(alu_val), 0);
        check("rst_resp_val", int'(resp_val), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_wb_val", int'(wb_val), 0);
        check("rst_resp_err", int'(resp_err), 0);
        @(posedge clk);
        #1 reset = 1;
        @(negedge clk);
        check("idle_req_rdy", int'(req_rdy), 1);
        issue(0, 8, 'hFF, 3, 1, 0, t); wait_done();
        issue(2, 5, 'hED, 1, 1, 0, t); wait_done();
        issue(0, 8, 'hFF, 5, 1, 2, t); wait_done();
        issue(12, 8, 'hFF, 2, 1, 0, t); wait_done();
        issue(0, 0, 'hFF, 2, 1, 0, t); wait_done();
        issue(0, 13, 'hFF, 4, 1, 0, t); wait_done();
        // Held response: second request waits on req_val until the cycle after the handshake.
        issue(1, 8, 'hAA, 6, 1, 0, ta);
        rdy_lo = ta + 6;
        rdy_hi = ta + 8;
        issue(3, 4, 'h0F, 7, 1, 0, tb);
        check("handshake_cycle", hs_cyc, ta + 9);
        check("accept_after_hs", tb, hs_cyc + 1);
        wait_done();
        issue(0, 8, 'hFF, 3, 1, 0, t);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 0;
        @(posedge clk);
        #1 reset = 1;
        alu_q.delete(); wb_q.delete(); resp_q.delete();
        @(negedge clk);
        check("abort_alu_val", int'(alu_val), 0);
        check("abort_wb_val", int'(wb_val), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_resp_val", int'(resp_val), 0);
        check("abort_req_rdy", int'(req_rdy), 1);
        issue(4, 7, 'h5B, 1, 1, 0, t); wait_done();
        rand_mode = 1;
        repeat (40) issue($urandom_range(0, 11), $urandom_range(0, 15), $urandom, $urandom_range(0, 7), 0, 0, t);
        rand_mode = 0;
        wait_done();
        check("alu_q_empty", alu_q.size(), 0);
        check("wb_q_empty", wb_q.size(), 0);
        check("resp_q_empty", resp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
